// File: rtl/id_ex_stage_pkg.sv
// Shared widths and operand-source encoding for the ID/EX stage.
package id_ex_stage_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int CTRL_W = 8;

  typedef enum logic [1:0] {
    SRC_RF    = 2'd0,
    SRC_WB    = 2'd1,
    SRC_MEM   = 2'd2,
    SRC_EXBYP = 2'd3
  } src_e;

endpackage

// File: rtl/id_ex_stage_fwd_select.sv
// Per-operand bypass priority selector: EX self-bypass > MEM result > WB data > register file.
module fwd_select
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          uses,
  input  logic [AW-1:0] rs,
  input  logic [DW-1:0] rf_rdata,
  input  logic          ex_valid,
  input  logic          ex_we,
  input  logic          ex_is_load,
  input  logic [AW-1:0] ex_rd,
  input  logic          exm_valid,
  input  logic          exm_we,
  input  logic          exm_is_load,
  input  logic [AW-1:0] exm_rd,
  input  logic [DW-1:0] exm_result,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] op,
  output logic          byp,
  output logic          load_haz
);

  logic match_x;
  logic match_m;
  logic match_w;
  src_e src;

  always_comb begin
    match_x  = uses & ex_valid & ex_we & (ex_rd == rs);
    match_m  = uses & exm_valid & exm_we & (exm_rd == rs);
    match_w  = uses & wb_we & (wb_rd == rs);
    load_haz = (match_x & ex_is_load) | (match_m & exm_is_load);

    src = SRC_RF;
    if (match_x)      src = SRC_EXBYP;
    else if (match_m) src = SRC_MEM;
    else if (match_w) src = SRC_WB;

    byp = 1'b0;
    op  = rf_rdata;
    case (src)
      // EX supplies the value itself next cycle, so the captured operand is unused.
      SRC_EXBYP: begin
        byp = 1'b1;
        op  = '0;
      end
      SRC_MEM: op = exm_result;
      SRC_WB:  op = wb_data;
      default: op = rf_rdata;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypassing, load-use hazard detection and bubble insertion.
module id_ex_stage #(
  parameter int DATA_W = id_ex_stage_pkg::DATA_W,
  parameter int ADDR_W = id_ex_stage_pkg::ADDR_W,
  parameter int CTRL_W = id_ex_stage_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic              flush,
  input  logic              exm_valid,
  input  logic              exm_we,
  input  logic              exm_is_load,
  input  logic [ADDR_W-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_we,
  output logic              ex_is_load,
  output logic [ADDR_W-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic              ex_byp1,
  output logic              ex_byp2
);

  logic              ex_valid_q, ex_valid_d;
  logic              ex_we_q, ex_we_d;
  logic              ex_is_load_q, ex_is_load_d;
  logic [ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [DATA_W-1:0] ex_op1_q, ex_op1_d;
  logic [DATA_W-1:0] ex_op2_q, ex_op2_d;
  logic              ex_byp1_q, ex_byp1_d;
  logic              ex_byp2_q, ex_byp2_d;

  logic [DATA_W-1:0] sel_op1, sel_op2;
  logic              sel_byp1, sel_byp2;
  logic              haz1, haz2;
  logic              haz, bubble;

  fwd_select #(.DW(DATA_W), .AW(ADDR_W)) u_fwd1 (
    .uses        (id_uses_rs1),
    .rs          (id_rs1),
    .rf_rdata    (rf_rdata1),
    .ex_valid    (ex_valid_q),
    .ex_we       (ex_we_q),
    .ex_is_load  (ex_is_load_q),
    .ex_rd       (ex_rd_q),
    .exm_valid   (exm_valid),
    .exm_we      (exm_we),
    .exm_is_load (exm_is_load),
    .exm_rd      (exm_rd),
    .exm_result  (exm_result),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .op          (sel_op1),
    .byp         (sel_byp1),
    .load_haz    (haz1)
  );

  fwd_select #(.DW(DATA_W), .AW(ADDR_W)) u_fwd2 (
    .uses        (id_uses_rs2),
    .rs          (id_rs2),
    .rf_rdata    (rf_rdata2),
    .ex_valid    (ex_valid_q),
    .ex_we       (ex_we_q),
    .ex_is_load  (ex_is_load_q),
    .ex_rd       (ex_rd_q),
    .exm_valid   (exm_valid),
    .exm_we      (exm_we),
    .exm_is_load (exm_is_load),
    .exm_rd      (exm_rd),
    .exm_result  (exm_result),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .op          (sel_op2),
    .byp         (sel_byp2),
    .load_haz    (haz2)
  );

  always_comb begin
    haz    = id_valid & (haz1 | haz2);
    // A flushed instruction is dead, so it must never hold the front end.
    stall  = haz & ~flush;
    bubble = ~id_valid | flush | haz;

    ex_valid_d   = 1'b0;
    ex_we_d      = 1'b0;
    ex_is_load_d = 1'b0;
    ex_rd_d      = '0;
    ex_ctrl_d    = '0;
    ex_op1_d     = '0;
    ex_op2_d     = '0;
    ex_byp1_d    = 1'b0;
    ex_byp2_d    = 1'b0;

    if (!bubble) begin
      ex_valid_d   = 1'b1;
      ex_we_d      = id_we;
      ex_is_load_d = id_is_load;
      ex_rd_d      = id_rd;
      ex_ctrl_d    = id_ctrl;
      ex_op1_d     = sel_op1;
      ex_op2_d     = sel_op2;
      ex_byp1_d    = sel_byp1;
      ex_byp2_d    = sel_byp2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_we_q      <= 1'b0;
      ex_is_load_q <= 1'b0;
      ex_rd_q      <= '0;
      ex_ctrl_q    <= '0;
      ex_op1_q     <= '0;
      ex_op2_q     <= '0;
      ex_byp1_q    <= 1'b0;
      ex_byp2_q    <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_we_q      <= ex_we_d;
      ex_is_load_q <= ex_is_load_d;
      ex_rd_q      <= ex_rd_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_op1_q     <= ex_op1_d;
      ex_op2_q     <= ex_op2_d;
      ex_byp1_q    <= ex_byp1_d;
      ex_byp2_q    <= ex_byp2_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_we      = ex_we_q;
  assign ex_is_load = ex_is_load_q;
  assign ex_rd      = ex_rd_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign ex_op1     = ex_op1_q;
  assign ex_op2     = ex_op2_q;
  assign ex_byp1    = ex_byp1_q;
  assign ex_byp2    = ex_byp2_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven bench for id_ex_stage: one row per cycle, expected EX outputs queued and checked after the edge.
module tb_id_ex_stage;

  typedef struct {
    logic        rst;
    logic        id_valid;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        u1;
    logic        u2;
    logic [2:0]  rd;
    logic        we;
    logic        ld;
    logic [7:0]  ctrl;
    logic [15:0] rf1;
    logic [15:0] rf2;
    logic        flush;
    logic        exm_valid;
    logic        exm_we;
    logic        exm_ld;
    logic [2:0]  exm_rd;
    logic [15:0] exm_res;
    logic        wb_we;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
  } in_t;

  typedef struct {
    logic        stall;
    logic        valid;
    logic        we;
    logic        ld;
    logic [2:0]  rd;
    logic [7:0]  ctrl;
    logic [15:0] op1;
    logic [15:0] op2;
    logic        b1;
    logic        b2;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_uses_rs1, id_uses_rs2, id_we, id_is_load, flush;
  logic [2:0]  id_rs1, id_rs2, id_rd, exm_rd, wb_rd, ex_rd;
  logic [7:0]  id_ctrl, ex_ctrl;
  logic [15:0] rf_rdata1, rf_rdata2, exm_result, wb_data, ex_op1, ex_op2;
  logic        exm_valid, exm_we, exm_is_load, wb_we;
  logic        stall, ex_valid, ex_we, ex_is_load, ex_byp1, ex_byp2;

  int checks = 0;
  int errors = 0;
  int row = 0;
  exp_t sb[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .id_ctrl(id_ctrl), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .flush(flush), .exm_valid(exm_valid), .exm_we(exm_we), .exm_is_load(exm_is_load),
    .exm_rd(exm_rd), .exm_result(exm_result), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_byp1(ex_byp1), .ex_byp2(ex_byp2)
  );

  function automatic in_t id_in(input logic v, input logic [2:0] s1, input logic [2:0] s2,
                                input logic u1, input logic u2, input logic [2:0] rd,
                                input logic we, input logic ld, input logic [7:0] ctrl,
                                input logic [15:0] rf1, input logic [15:0] rf2);
    in_t t;
    t.rst = 0; t.id_valid = v; t.rs1 = s1; t.rs2 = s2; t.u1 = u1; t.u2 = u2;
    t.rd = rd; t.we = we; t.ld = ld; t.ctrl = ctrl; t.rf1 = rf1; t.rf2 = rf2;
    t.flush = 0; t.exm_valid = 0; t.exm_we = 0; t.exm_ld = 0; t.exm_rd = 0; t.exm_res = 0;
    t.wb_we = 0; t.wb_rd = 0; t.wb_data = 0;
    return t;
  endfunction

  function automatic exp_t cap(input logic s, input logic [2:0] rd, input logic we, input logic ld,
                               input logic [7:0] ctrl, input logic [15:0] op1, input logic [15:0] op2,
                               input logic b1, input logic b2);
    exp_t e;
    e.stall = s; e.valid = 1; e.we = we; e.ld = ld; e.rd = rd; e.ctrl = ctrl;
    e.op1 = op1; e.op2 = op2; e.b1 = b1; e.b2 = b2;
    return e;
  endfunction

  function automatic exp_t bub(input logic s);
    exp_t e;
    e.stall = s; e.valid = 0; e.we = 0; e.ld = 0; e.rd = 0; e.ctrl = 0;
    e.op1 = 0; e.op2 = 0; e.b1 = 0; e.b2 = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input in_t t);
    rst = t.rst; id_valid = t.id_valid; id_rs1 = t.rs1; id_rs2 = t.rs2;
    id_uses_rs1 = t.u1; id_uses_rs2 = t.u2; id_rd = t.rd; id_we = t.we;
    id_is_load = t.ld; id_ctrl = t.ctrl; rf_rdata1 = t.rf1; rf_rdata2 = t.rf2;
    flush = t.flush; exm_valid = t.exm_valid; exm_we = t.exm_we; exm_is_load = t.exm_ld;
    exm_rd = t.exm_rd; exm_result = t.exm_res; wb_we = t.wb_we; wb_rd = t.wb_rd;
    wb_data = t.wb_data;
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    drive(v.i);
    #1;
    chk("stall", {31'b0, stall}, {31'b0, v.e.stall});
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard row %0d: got empty queue expected entry", row);
    end else begin
      e = sb.pop_front();
      chk("ex_valid",   {31'b0, ex_valid},   {31'b0, e.valid});
      chk("ex_we",      {31'b0, ex_we},      {31'b0, e.we});
      chk("ex_is_load", {31'b0, ex_is_load}, {31'b0, e.ld});
      chk("ex_rd",      {29'b0, ex_rd},      {29'b0, e.rd});
      chk("ex_ctrl",    {24'b0, ex_ctrl},    {24'b0, e.ctrl});
      chk("ex_op1",     {16'b0, ex_op1},     {16'b0, e.op1});
      chk("ex_op2",     {16'b0, ex_op2},     {16'b0, e.op2});
      chk("ex_byp1",    {31'b0, ex_byp1},    {31'b0, e.b1});
      chk("ex_byp2",    {31'b0, ex_byp2},    {31'b0, e.b2});
    end
  endtask

  initial begin
    in_t  i;
    vec_t v;

    // Reset held two cycles with a valid instruction present.
    i = id_in(1, 3, 0, 0, 0, 1, 1, 0, 8'h11, 16'h1234, 0); i.rst = 1;
    v.i = i; v.e = bub(0); tbl.push_back(v);
    i.u1 = 1; v.i = i; tbl.push_back(v);
    i = id_in(1, 3, 0, 1, 0, 1, 1, 0, 8'h11, 16'h1234, 0);
    v.i = i; v.e = cap(0, 1, 1, 0, 8'h11, 16'h1234, 0, 0, 0); tbl.push_back(v);
    // WB bypass, then the same with rs1 unused.
    i = id_in(1, 2, 0, 1, 0, 6, 1, 0, 8'h22, 0, 0); i.wb_we = 1; i.wb_rd = 2; i.wb_data = 16'hBEEF;
    v.i = i; v.e = cap(0, 6, 1, 0, 8'h22, 16'hBEEF, 0, 0, 0); tbl.push_back(v);
    i.u1 = 0; i.rf1 = 16'h1111;
    v.i = i; v.e = cap(0, 6, 1, 0, 8'h22, 16'h1111, 0, 0, 0); tbl.push_back(v);
    // MEM beats WB; then EX self-bypass beats MEM.
    i = id_in(1, 0, 5, 0, 1, 5, 1, 0, 8'h33, 0, 16'h0001);
    i.exm_valid = 1; i.exm_we = 1; i.exm_rd = 5; i.exm_res = 16'h00AA;
    i.wb_we = 1; i.wb_rd = 5; i.wb_data = 16'h00BB;
    v.i = i; v.e = cap(0, 5, 1, 0, 8'h33, 0, 16'h00AA, 0, 0); tbl.push_back(v);
    i = id_in(1, 0, 5, 0, 1, 7, 1, 0, 8'h44, 0, 16'h0002);
    i.exm_valid = 1; i.exm_we = 1; i.exm_rd = 5; i.exm_res = 16'h00CC;
    v.i = i; v.e = cap(0, 7, 1, 0, 8'h44, 0, 0, 0, 1); tbl.push_back(v);
    // Load-use: two bubbles, then operands from WB.
    i = id_in(1, 0, 0, 0, 0, 4, 1, 1, 8'h55, 0, 0);
    v.i = i; v.e = cap(0, 4, 1, 1, 8'h55, 0, 0, 0, 0); tbl.push_back(v);
    i = id_in(1, 4, 4, 1, 1, 1, 1, 0, 8'h66, 0, 0);
    v.i = i; v.e = bub(1); tbl.push_back(v);
    i.exm_valid = 1; i.exm_we = 1; i.exm_ld = 1; i.exm_rd = 4; i.exm_res = 16'hDEAD;
    v.i = i; v.e = bub(1); tbl.push_back(v);
    i = id_in(1, 4, 4, 1, 1, 1, 1, 0, 8'h66, 0, 0); i.wb_we = 1; i.wb_rd = 4; i.wb_data = 16'h0F0F;
    v.i = i; v.e = cap(0, 1, 1, 0, 8'h66, 16'h0F0F, 16'h0F0F, 0, 0); tbl.push_back(v);
    // Flush during a hazard cycle.
    i = id_in(1, 0, 0, 0, 0, 4, 1, 1, 8'h55, 0, 0);
    v.i = i; v.e = cap(0, 4, 1, 1, 8'h55, 0, 0, 0, 0); tbl.push_back(v);
    i = id_in(1, 4, 4, 1, 1, 1, 1, 0, 8'h66, 0, 0); i.flush = 1;
    v.i = i; v.e = bub(0); tbl.push_back(v);
    i = id_in(1, 3, 0, 1, 0, 2, 1, 0, 8'h77, 16'h0003, 0);
    v.i = i; v.e = cap(0, 2, 1, 0, 8'h77, 16'h0003, 0, 0, 0); tbl.push_back(v);
    // Reset in the second stall cycle.
    i = id_in(1, 0, 0, 0, 0, 4, 1, 1, 8'h55, 0, 0);
    v.i = i; v.e = cap(0, 4, 1, 1, 8'h55, 0, 0, 0, 0); tbl.push_back(v);
    i = id_in(1, 4, 4, 1, 1, 1, 1, 0, 8'h66, 0, 0);
    v.i = i; v.e = bub(1); tbl.push_back(v);
    i.rst = 1; i.exm_valid = 1; i.exm_we = 1; i.exm_ld = 1; i.exm_rd = 4;
    v.i = i; v.e = bub(1); tbl.push_back(v);
    i = id_in(1, 4, 4, 1, 1, 1, 1, 0, 8'h66, 16'h4444, 16'h4444);
    v.i = i; v.e = cap(0, 1, 1, 0, 8'h66, 16'h4444, 16'h4444, 0, 0); tbl.push_back(v);
    // Register 0 is bypassed like any other; invalid ID slot gives a bubble.
    i = id_in(1, 0, 0, 1, 0, 3, 0, 0, 8'h88, 0, 0); i.wb_we = 1; i.wb_rd = 0; i.wb_data = 16'h5A5A;
    v.i = i; v.e = cap(0, 3, 0, 0, 8'h88, 16'h5A5A, 0, 0, 0); tbl.push_back(v);
    i = id_in(0, 3, 3, 1, 1, 5, 1, 0, 8'h99, 16'h0001, 16'h0001);
    v.i = i; v.e = bub(0); tbl.push_back(v);
    // rs1==rs2 both from MEM, then EX self-bypass on op1.
    i = id_in(1, 6, 6, 1, 1, 2, 1, 0, 8'hAB, 16'h0001, 16'h0001);
    i.exm_valid = 1; i.exm_we = 1; i.exm_rd = 6; i.exm_res = 16'h0066;
    i.wb_we = 1; i.wb_rd = 6; i.wb_data = 16'h0077;
    v.i = i; v.e = cap(0, 2, 1, 0, 8'hAB, 16'h0066, 16'h0066, 0, 0); tbl.push_back(v);
    i = id_in(1, 2, 2, 1, 0, 3, 1, 0, 8'hCD, 16'h0005, 16'h0005);
    v.i = i; v.e = cap(0, 3, 1, 0, 8'hCD, 0, 16'h0005, 1, 0); tbl.push_back(v);

    foreach (tbl[k]) begin
      row = k;
      step(tbl[k]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage. It sits directly downstream of the 8x16 register file.
- Captures the register-file read data and the decoded control fields into the ID/EX register.
- Applies WB and MEM bypassing, flags EX-to-EX bypass for the execute stage, and detects load-use hazards.
- On a hazard it stalls IF/ID and inserts a bubble.

Parameters:
DATA_W, 16, operand/result width
ADDR_W, 3, register address width (8 registers)
CTRL_W, 8, opaque decoded-control bundle width, passed through untouched

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, synchronous, active-high
id_valid  in  1  ID slot holds a real instruction
id_rs1  in  ADDR_W  source 1 address (also drives register-file read port 1)
id_rs2  in  ADDR_W  source 2 address
id_uses_rs1  in  1  instruction reads rs1
id_uses_rs2  in  1  instruction reads rs2
id_rd  in  ADDR_W  destination address
id_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a memory load
id_ctrl  in  CTRL_W  decoded control bundle
rf_rdata1  in  DATA_W  register-file read data 1 (register-file state before this cycle's WB write)
rf_rdata2  in  DATA_W  register-file read data 2
flush  in  1  kill ID instruction (taken branch resolved in EX)
exm_valid  in  1  MEM-stage (EX/MEM register) instruction valid
exm_we  in  1  MEM-stage instruction writes rd
exm_is_load  in  1  MEM-stage instruction is a load
exm_rd  in  ADDR_W  MEM-stage destination
exm_result  in  DATA_W  MEM-stage ALU result
wb_we  in  1  WB write enable (same signal as register-file write enable)
wb_rd  in  ADDR_W  WB destination
wb_data  in  DATA_W  WB data
stall  out  1  hold PC and IF/ID; combinational
ex_valid  out  1  EX slot valid
ex_we  out  1  registered id_we
ex_is_load  out  1  registered id_is_load
ex_rd  out  ADDR_W  registered destination
ex_ctrl  out  CTRL_W  registered control bundle
ex_op1  out  DATA_W  registered operand 1
ex_op2  out  DATA_W  registered operand 2
ex_byp1  out  1  EX must substitute its own previous ALU result for op1
ex_byp2  out  1  same, for op2

Behaviour:
- Reset: all outputs 0 on the first posedge with rst=1. rst overrides flush and stall.
- Match definitions, for n in {1,2}:
  - matchX_n = id_uses_rsn & ex_valid & ex_we & (ex_rd==id_rsn)
  - matchM_n = id_uses_rsn & exm_valid & exm_we & (exm_rd==id_rsn)
  - matchW_n = id_uses_rsn & wb_we & (wb_rd==id_rsn)
- Register 0 is an ordinary register; there is no zero exclusion.
- Hazard: haz = id_valid & OR over n of [(matchX_n & ex_is_load) | (matchM_n & exm_is_load)].
  - A load-use dependency therefore costs 2 bubbles when the load is in EX and 1 when it is in MEM.
  - The data is then taken from WB.
- Outputs of the hazard logic:
  - stall = haz & ~flush
  - bubble = ~id_valid | flush | haz
- On bubble:
  - Next posedge: ex_valid, ex_we, ex_is_load, ex_byp1/2 <= 0 and ex_ctrl <= 0.
  - ex_op1/2 and ex_rd are don't-care; they are driven to 0 for determinism.
- Otherwise, capture. Operand n selection priority:
  - matchX_n (non-load) -> ex_byp_n=1, ex_opn=0
  - else matchM_n -> exm_result
  - else matchW_n -> wb_data
  - else rf_rdata_n
- WB bypass is mandatory. The register file reads on the falling edge and writes on the rising edge, so the read data does not include the write committed at the end of this cycle.
- Flush beats hazard: a flushed instruction never stalls.
- Latency: 1 cycle from ID to EX outputs.
- Throughput: 1 instruction/cycle with no hazard.
- Stall duration: at most 2 consecutive cycles per dependency.
- id_* inputs are held by upstream while stall=1. The stage does not re-check hold; it re-evaluates every cycle.
- rs1==rs2 with both used: both operands resolve independently and identically.

Decomposition:
- Shared package holds DATA_W, ADDR_W, CTRL_W and the operand-source encoding (SRC_RF, SRC_WB, SRC_MEM, SRC_EXBYP).
- One sub-module, fwd_select: purely combinational per-operand priority selector.
  - Instantiated twice.
  - Outputs the operand value, the byp flag and a load-hazard bit.

Test Plan:
1. rst=1 for 2 cycles with id_valid=1 -> all outputs 0, stall=0; after release, rs1=3 (rf=0x1234) captured as ex_op1=0x1234, ex_valid=1.
2. WB bypass: wb_we=1, wb_rd=2, wb_data=0xBEEF, rf_rdata1=0x0000, id_rs1=2 -> ex_op1=0xBEEF; repeat with id_uses_rs1=0 -> ex_op1=rf value.
3. Priority: exm_rd=wb_rd=id_rs2=5, exm_result=0x00AA, wb_data=0x00BB -> ex_op2=0x00AA; then ADD r5 in EX followed by user of r5 -> ex_byp2=1.
4. Load-use: LOAD r4 then ADD r1,r4,r4 -> stall=1 for 2 cycles, 2 bubbles (ex_valid=0); third cycle ex_op1=ex_op2=wb_data=0x0F0F, ex_valid=1.
5. Flush during hazard: conditions of test 4 with flush=1 in the first stall cycle -> stall=0, ex_valid=0 next cycle, no further stall.
6. Mid-stall reset: rst=1 in the second stall cycle -> next cycle all outputs 0, stall follows the inputs only (0 when ex_valid=0 and exm_valid=0).
